// File: rtl/blur_wr_arbiter.sv
// Round-robin scheduler that lets four blur engines share one frame-memory write port.
// Each layer owns a linear COLS*ROWS address window; the write port is registered and honours backpressure.
module blur_wr_arbiter #(
  parameter int COLS = 640,
  parameter int ROWS = 480,
  parameter int DW   = 8,
  parameter int AW   = 21
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      req_valid,
  input  logic [4*DW-1:0] req_data,
  output logic [3:0]      req_ready,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_ready,
  output logic [3:0]      layer_done,
  output logic            frame_done,
  output logic            busy
);

  localparam int PIX = COLS * ROWS;
  localparam int CW  = (PIX > 1) ? $clog2(PIX) : 1;
  localparam logic [CW-1:0] LAST = CW'(PIX - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_reg;
  logic [1:0]      rr_reg;
  logic [CW-1:0]   cnt_reg [4];
  logic [3:0]      done_reg;
  logic            we_reg;
  logic [AW-1:0]   addr_reg;
  logic [DW-1:0]   wdata_reg;
  logic            frame_done_reg;
  logic            busy_reg;

  logic            out_free;
  logic [3:0]      eligible;
  logic [3:0]      grant_next;
  logic [1:0]      gidx_next;
  logic            found_next;
  logic [1:0]      idx;
  logic [AW-1:0]   layer_addr [4];
  logic [DW-1:0]   layer_data [4];
  logic [3:0]      layer_last;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_layer
      localparam logic [AW-1:0] BASE = AW'(gi * PIX);
      assign layer_addr[gi] = BASE + AW'(cnt_reg[gi]);
      assign layer_data[gi] = req_data[gi*DW +: DW];
      assign layer_last[gi] = (cnt_reg[gi] == LAST);
    end
  endgenerate

  assign out_free = ~we_reg | mem_ready;
  assign eligible = req_valid & ~done_reg;

  // Search downward so the candidate closest to rr is the one left standing.
  always_comb begin
    grant_next = '0;
    gidx_next  = rr_reg;
    found_next = 1'b0;
    idx        = '0;
    if (state_reg == RUN && out_free) begin
      for (int k = 3; k >= 0; k--) begin
        idx = rr_reg + 2'(k);
        if (eligible[idx]) begin
          gidx_next  = idx;
          found_next = 1'b1;
        end
      end
    end
    if (found_next) grant_next = 4'b0001 << gidx_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      rr_reg         <= '0;
      done_reg       <= '0;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      frame_done_reg <= 1'b0;
      busy_reg       <= 1'b0;
      for (int i = 0; i < 4; i++) cnt_reg[i] <= '0;
    end else begin
      // A grant is only possible when the register is free, so it never overwrites a stalled write.
      if (found_next) begin
        we_reg    <= 1'b1;
        addr_reg  <= layer_addr[gidx_next];
        wdata_reg <= layer_data[gidx_next];
        rr_reg    <= gidx_next + 2'd1;
        if (layer_last[gidx_next]) done_reg[gidx_next] <= 1'b1;
        else                       cnt_reg[gidx_next]  <= cnt_reg[gidx_next] + 1'b1;
      end else if (mem_ready) begin
        we_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= RUN;
            busy_reg  <= 1'b1;
            rr_reg    <= '0;
            done_reg  <= '0;
            for (int i = 0; i < 4; i++) cnt_reg[i] <= '0;
          end
        end
        RUN: begin
          if (&done_reg && out_free) begin
            state_reg      <= DONE;
            frame_done_reg <= 1'b1;
          end
        end
        DONE: begin
          state_reg      <= IDLE;
          frame_done_reg <= 1'b0;
          busy_reg       <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ready  = grant_next;
  assign mem_we     = we_reg;
  assign mem_addr   = addr_reg;
  assign mem_wdata  = wdata_reg;
  assign layer_done = done_reg;
  assign frame_done = frame_done_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_blur_wr_arbiter.sv
// Scoreboard bench for blur_wr_arbiter: a counting reference model predicts grants and writes,
// and an independent monitor retires each write handshake against the expected queue.
module tb_blur_wr_arbiter;
  localparam int COLS = 4;
  localparam int ROWS = 2;
  localparam int DW   = 8;
  localparam int AW   = 5;
  localparam int N    = COLS * ROWS;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [3:0]      req_valid;
  logic [4*DW-1:0] req_data;
  logic [3:0]      req_ready;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_ready;
  logic [3:0]      layer_done;
  logic            frame_done;
  logic            busy;

  always #5 clk = ~clk;

  blur_wr_arbiter #(.COLS(COLS), .ROWS(ROWS), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .layer_done(layer_done), .frame_done(frame_done), .busy(busy)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  int  checks   = 0;
  int  failures = 0;
  wr_t exp_q[$];

  // Reference model: phase 0 idle, 1 frame running, 2 frame-done cycle.
  int  m_phase = 0;
  int  m_cnt[4] = '{0, 0, 0, 0};
  int  m_rr = 0;
  bit  m_pend = 1'b0;
  bit  m_fresh = 1'b1;

  int  wr_count = 0;
  bit  seen[4*N];

  // Engine-side stimulus state.
  int       k_sent[4];
  logic [3:0] en = 4'h0;
  logic [3:0] hold_done = 4'h0;
  int       vprob = 100;
  bit       mr_rand = 1'b0;
  int       stall = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [3:0] done_mask;
    logic [3:0] exp_ready;
    int  g;
    int  j;
    bit  drain;
    wr_t w;
    done_mask = 4'h0;
    for (int i = 0; i < 4; i++) if (m_cnt[i] == N) done_mask[i] = 1'b1;
    g = -1;
    if (m_phase == 1 && (!m_pend || mem_ready)) begin
      for (int k = 0; k < 4; k++) begin
        j = (m_rr + k) % 4;
        if (g < 0 && req_valid[j] && !done_mask[j]) g = j;
      end
    end
    exp_ready = (g >= 0) ? (4'b0001 << g) : 4'h0;
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    check("mem_we", 64'(mem_we), 64'(m_pend));
    check("layer_done", 64'(layer_done), 64'(done_mask));
    check("busy", 64'(busy), 64'(m_phase != 0));
    check("frame_done", 64'(frame_done), 64'(m_phase == 2));
    if (m_fresh) begin
      check("reset_addr", 64'(mem_addr), 64'd0);
      check("reset_wdata", 64'(mem_wdata), 64'd0);
    end
    if (rst) begin
      m_phase = 0; m_rr = 0; m_pend = 1'b0; m_fresh = 1'b1;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      exp_q.delete();
    end else begin
      drain = !m_pend || mem_ready;
      if (m_pend && mem_ready) m_pend = 1'b0;
      if (g >= 0) begin
        w.addr = AW'(g * N + m_cnt[g]);
        w.data = req_data[g*DW +: DW];
        exp_q.push_back(w);
        m_cnt[g]++;
        m_rr = (g + 1) % 4;
        m_pend = 1'b1;
        m_fresh = 1'b0;
      end
      case (m_phase)
        0: if (start) begin
             m_phase = 1; m_rr = 0;
             for (int i = 0; i < 4; i++) m_cnt[i] = 0;
           end
        1: if (done_mask == 4'hF && drain) m_phase = 2;
        default: m_phase = 0;
      endcase
    end
  endtask

  initial begin : model
    @(posedge clk);
    forever begin
      @(negedge clk);
      model_step();
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst && mem_we) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_write: got addr %0d data %0h, expected no write", mem_addr, mem_wdata);
        end else begin
          check("mem_addr", 64'(mem_addr), 64'(exp_q[0].addr));
          check("mem_wdata", 64'(mem_wdata), 64'(exp_q[0].data));
          if (mem_ready) begin
            $display("write addr=%0d data=%0h", mem_addr, mem_wdata);
            void'(exp_q.pop_front());
            wr_count++;
            if (int'(mem_addr) < 4*N) seen[mem_addr] = 1'b1;
          end
        end
      end
    end
  end

  // One clock of engine behaviour: valid is held until the pixel is taken, never derived from ready.
  task automatic tick();
    logic [3:0] x;
    @(negedge clk);
    x = req_valid & req_ready;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (x[i]) k_sent[i]++;
      if (x[i] || !req_valid[i]) begin
        if (k_sent[i] >= N) req_valid[i] = hold_done[i];
        else                req_valid[i] = en[i] && ($urandom_range(99) < vprob);
      end
      req_data[i*DW +: DW] = DW'(16 * i + k_sent[i]);
    end
    if (stall > 0) begin
      mem_ready = 1'b0;
      stall--;
    end else begin
      mem_ready = mr_rand ? ($urandom_range(99) < 70) : 1'b1;
    end
  endtask

  task automatic new_frame(input logic [3:0] e, input int vp, input bit mr);
    for (int i = 0; i < 4; i++) k_sent[i] = 0;
    en = e; vprob = vp; mr_rand = mr; hold_done = 4'h0;
    start = 1'b1;
    tick();
  endtask

  task automatic wait_frame_end(input int budget);
    int n;
    n = 0;
    while (m_phase != 0 && n < budget) begin
      tick();
      n++;
    end
    if (m_phase != 0) begin
      checks++; failures++;
      $display("FAIL frame_timeout: still busy after %0d cycles, expected frame end", budget);
    end
    repeat (2) tick();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin : stimulus
    int n;
    int nseen;
    rst = 1'b1; start = 1'b0; req_valid = 4'hF; req_data = '0; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) k_sent[i] = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0; req_valid = 4'h0;
    tick();

    // Single layer: only blur3x3 streams; the frame never completes.
    new_frame(4'b0001, 100, 1'b0);
    n = 0;
    while (k_sent[0] < N && n < 60) begin tick(); n++; end
    repeat (3) tick();
    check("single_layer_done", 64'(layer_done), 64'h1);
    pulse_reset();
    tick();

    // Full round robin with a 3-cycle memory stall in the middle.
    wr_count = 0;
    for (int a = 0; a < 4*N; a++) seen[a] = 1'b0;
    new_frame(4'hF, 100, 1'b0);
    repeat (9) tick();
    stall = 3;
    wait_frame_end(200);
    nseen = 0;
    for (int a = 0; a < 4*N; a++) if (seen[a]) nseen++;
    check("rr_write_count", 64'(wr_count), 64'(4*N));
    check("rr_unique_addrs", 64'(nseen), 64'(4*N));
    check("rr_queue_empty", 64'(exp_q.size()), 64'd0);

    // Layer 2 finishes first and keeps requesting; a mid-frame start must be ignored.
    new_frame(4'b0100, 100, 1'b0);
    hold_done = 4'b0100;
    n = 0;
    while (k_sent[2] < N && n < 60) begin tick(); n++; end
    en = 4'hF; vprob = 60; mr_rand = 1'b1;
    repeat (5) tick();
    start = 1'b1;
    tick();
    wait_frame_end(600);

    // Randomised frames.
    repeat (3) begin
      new_frame(4'hF, 40, 1'b1);
      repeat (10) tick();
      start = 1'b1;
      tick();
      wait_frame_end(800);
    end

    // Reset after 13 writes, then a fresh frame fed by blur5x5_1 alone.
    wr_count = 0;
    new_frame(4'hF, 100, 1'b0);
    n = 0;
    while (wr_count < 13 && n < 100) begin tick(); n++; end
    pulse_reset();
    tick();
    new_frame(4'b0010, 100, 1'b0);
    n = 0;
    while (k_sent[1] < N && n < 60) begin tick(); n++; end
    repeat (2) tick();
    check("layer1_only_done", 64'(layer_done), 64'h2);
    pulse_reset();
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/blur_wr_arbiter.md
# blur_wr_arbiter

Round-robin write scheduler that shares the single frame-memory write port among the four Gaussian blur engines of the SIFT scale-space stage: blur3x3, blur5x5_1, blur5x5_2 and blur7x7. Each engine streams one raster-ordered blurred frame. The block accepts pixels over valid/ready, generates per-layer linear addresses, and drives one registered write port with backpressure. It reports per-layer completion and a frame-done pulse to the pyramid sequencer.

## Interface
Parameters:
- COLS, 640, pixels per row
- ROWS, 480, rows per frame
- DW, 8, pixel width
- AW, 21, memory address width; must satisfy 2^AW >= 4*COLS*ROWS

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE
- req_valid  in  4  per-layer pixel valid; bit 0 = blur3x3, 1 = blur5x5_1, 2 = blur5x5_2, 3 = blur7x7
- req_data  in  4*DW  per-layer pixel; layer i occupies bits [i*DW +: DW]
- req_ready  out  4  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i]
- mem_we  out  1  write request, registered
- mem_addr  out  AW  write address, registered
- mem_wdata  out  DW  write data, registered
- mem_ready  in  1  memory accepts the write this cycle when mem_we & mem_ready
- layer_done  out  4  sticky; layer i has transferred COLS*ROWS pixels
- frame_done  out  1  one-cycle pulse at end of frame
- busy  out  1  high in RUN and DONE

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start. This clears the four pixel counters and layer_done, and sets the rr pointer to 0.
  - RUN -> DONE when layer_done == 4'hF and the output register is empty, or is being drained this cycle.
  - DONE -> IDLE unconditionally after one cycle. frame_done = 1 only in DONE.
- start outside IDLE is ignored.
- Output register (mem_we/addr/wdata) is free when mem_we == 0 or mem_ready == 1.
- Grant rules (RUN only):
  - eligible = req_valid & ~layer_done.
  - If the output register is free and eligible != 0, req_ready is the first eligible bit found by searching rr, rr+1, …, mod 4.
  - Otherwise req_ready = 0.
  - req_ready is combinational from req_valid, layer_done, rr, mem_we and mem_ready. Requesters must not make valid depend on ready.
- On a transfer from layer i:
  - mem_wdata <= req_data[i]
  - mem_addr <= i*COLS*ROWS + cnt[i]
  - mem_we <= 1
  - cnt[i] <= cnt[i]+1
  - rr <= (i+1) mod 4
  - If cnt[i] == COLS*ROWS-1, layer_done[i] <= 1 and cnt[i] holds. No wrap.
- With no transfer and mem_ready == 1, mem_we <= 0. With mem_ready == 0, mem_we/addr/wdata hold unchanged.
- Counters are unsigned, ceil(log2(COLS*ROWS)) bits. The base address is a constant i*COLS*ROWS computed at elaboration. Address arithmetic is unsigned and AW-wide with no overflow, per the AW constraint.
- A done layer asserting req_valid is never granted. Its data is neither written nor counted.
- In IDLE and DONE, req_ready = 0.

## Timing
- Reset values: req_ready = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, layer_done = 0, frame_done = 0, busy = 0. State = IDLE, rr = 0, counters = 0.
- rst mid-frame: the next edge returns to IDLE with all values above. Any pending write is dropped, not completed.
- Latency: a transfer in cycle t gives mem_we = 1 with its addr/data in cycle t+1.
- Throughput: 1 pixel/cycle total when mem_ready stays high. Four continuously valid layers each get 1/4.
- Backpressure: while mem_we & ~mem_ready, req_ready = 0 and the outputs are stable. In the cycle mem_ready rises, a new grant may be issued, so the port runs back-to-back.
- rr changes only on a transfer. Idle cycles do not rotate it.
- frame_done rises the cycle after the final mem_we & mem_ready handshake. busy falls with the DONE -> IDLE transition, so it is low the cycle after frame_done.
- start and rst in the same cycle: rst wins.

## Test plan
Bench parameters: COLS = 4, ROWS = 2 (8 pixels per layer), AW = 5.
- Reset: hold rst for 2 cycles with req_valid = 4'hF -> every output is 0, req_ready stays 0, busy = 0.
- Single layer: start, then only layer 0 valid with data 0..7 and mem_ready = 1 -> mem_addr 0..7 carry data 0..7, each one cycle after its transfer. layer_done = 4'b0001 after the 8th transfer. frame_done does not fire.
- Full round robin: start, all four layers valid continuously, layer i data = 16*i + k, mem_ready = 1.
  - Grant order is 0,1,2,3 repeating.
  - mem_addr sequence is 0,8,16,24,1,9,17,25,…,31.
  - 32 back-to-back writes, then frame_done high for exactly one cycle, then busy = 0.
- Backpressure: during the round-robin run, drop mem_ready for 3 cycles while mem_we = 1 -> mem_addr/mem_wdata are frozen and req_ready = 0 throughout. No pixel is lost or duplicated, verified by a scoreboard of 32 unique addresses.
- Done-layer masking and start while busy: finish layer 2 early and keep its req_valid high; pulse start mid-frame -> layer 2 is never granted again. The frame does not restart, with counters unchanged, and rr skips bit 2.
- Reset mid-frame: assert rst after 13 writes -> next cycle all outputs are 0. A new start followed by layer 1 valid gives the first mem_addr = 8.
